// File: rtl/sw_ctrl_pkg.sv
// Shared state encoding for the stopwatch mode controller.
// Encodings 5-7 are never entered; the FSM sends them to IDLE.
package sw_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_SET_MIN = 3'd3,
        ST_SET_SEC = 3'd4
    } sw_state_e;

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: 2-FF synchroniser, stable-level debouncer and a 1-cycle press pulse
// on the debounced rising edge.
module key_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_RAW,
    output logic PRESS
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= KEY_RAW;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            // Any return to the accepted level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: debounced keys drive a RUN/PAUSE/SET FSM that gates the 1 Hz
// tick, pulses clear/increment to the counters and blinks the digit being edited.
module stopwatch_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN1HZ,
    input  logic               KEY_START,
    input  logic               KEY_MODE,
    input  logic               KEY_UP,
    output logic               TICK,
    output logic               CLR,
    output logic               INC_SEC,
    output logic               INC_MIN,
    output logic               BLANK_SEC,
    output logic               BLANK_MIN,
    output logic [STATE_W-1:0] STATE
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic press_start;
    logic press_mode;
    logic press_up;

    sw_state_e     state_q, state_d;
    logic          clr_q, clr_d;
    logic          inc_min_q, inc_min_d;
    logic          inc_sec_q, inc_sec_d;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_ph_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .CLK     (CLK),
        .RST     (RST),
        .KEY_RAW (KEY_START),
        .PRESS   (press_start)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .CLK     (CLK),
        .RST     (RST),
        .KEY_RAW (KEY_MODE),
        .PRESS   (press_mode)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK     (CLK),
        .RST     (RST),
        .KEY_RAW (KEY_UP),
        .PRESS   (press_up)
    );

    // The if/else-if chains encode START > MODE > UP priority.
    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        inc_min_d = 1'b0;
        inc_sec_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_start)     state_d = ST_RUN;
                else if (press_mode) state_d = ST_SET_MIN;
            end
            ST_RUN: begin
                if (press_start) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (press_start) begin
                    state_d = ST_RUN;
                end else if (press_mode) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (press_start)     state_d = ST_RUN;
                else if (press_mode) state_d = ST_SET_SEC;
                else if (press_up)   inc_min_d = 1'b1;
            end
            ST_SET_SEC: begin
                if (press_start)     state_d = ST_RUN;
                else if (press_mode) state_d = ST_IDLE;
                else if (press_up)   inc_sec_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            clr_q     <= 1'b0;
            inc_min_q <= 1'b0;
            inc_sec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            inc_min_q <= inc_min_d;
            inc_sec_q <= inc_sec_d;
        end
    end

    // Restart the blink on entry and on every edit so the digit is visible immediately.
    always_ff @(posedge CLK) begin
        if (RST || (state_d != state_q) || inc_min_d || inc_sec_d) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (state_q == ST_SET_MIN || state_q == ST_SET_SEC) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end
    end

    assign TICK      = EN1HZ & (state_q == ST_RUN);
    assign CLR       = clr_q;
    assign INC_MIN   = inc_min_q;
    assign INC_SEC   = inc_sec_q;
    assign BLANK_MIN = blink_ph_q & (state_q == ST_SET_MIN);
    assign BLANK_SEC = blink_ph_q & (state_q == ST_SET_SEC);
    assign STATE     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4, BLINK_DIV=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_ctrl;

    logic       CLK;
    logic       RST;
    logic       EN1HZ;
    logic       KEY_START;
    logic       KEY_MODE;
    logic       KEY_UP;
    logic       TICK;
    logic       CLR;
    logic       INC_SEC;
    logic       INC_MIN;
    logic       BLANK_SEC;
    logic       BLANK_MIN;
    logic [2:0] STATE;

    int nchecks = 0;
    int nerrors = 0;

    stopwatch_ctrl #(.DB_CYCLES(4), .BLINK_DIV(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN1HZ     (EN1HZ),
        .KEY_START (KEY_START),
        .KEY_MODE  (KEY_MODE),
        .KEY_UP    (KEY_UP),
        .TICK      (TICK),
        .CLR       (CLR),
        .INC_SEC   (INC_SEC),
        .INC_MIN   (INC_MIN),
        .BLANK_SEC (BLANK_SEC),
        .BLANK_MIN (BLANK_MIN),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; EN1HZ = 1'b0; KEY_START = 1'b0; KEY_MODE = 1'b0; KEY_UP = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Clean press: returns at the sample where the resulting state change is visible
    // (press pulse 7 cycles after the raw rise, FSM reacts one cycle later).
    task automatic press_keys(input logic s, input logic m, input logic u);
        KEY_START = s; KEY_MODE = m; KEY_UP = u;
        repeat (8) @(negedge CLK);
    endtask

    task automatic release_keys();
        KEY_START = 1'b0; KEY_MODE = 1'b0; KEY_UP = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; EN1HZ = 1'b0; KEY_START = 1'b0; KEY_MODE = 1'b0; KEY_UP = 1'b0;
        repeat (3) @(negedge CLK);
        nchecks++;
        if (STATE !== 3'd0) begin
            nerrors++; $display("FAIL reset_state: got %0d want 0", STATE);
        end
        nchecks++;
        if ({TICK, CLR, INC_SEC, INC_MIN, BLANK_SEC, BLANK_MIN} !== 6'b0) begin
            nerrors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {TICK, CLR, INC_SEC, INC_MIN, BLANK_SEC, BLANK_MIN});
        end
        RST = 1'b0;
    endtask

    task automatic test_debounce();
        logic [2:0] exp;
        do_reset();
        // Bounce: 1 for 2 cycles, 0 for 2 cycles, then held 1.
        KEY_START = 1'b1;
        repeat (2) @(negedge CLK);
        KEY_START = 1'b0;
        repeat (2) @(negedge CLK);
        KEY_START = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            exp = (k >= 8) ? 3'd1 : 3'd0;
            nchecks++;
            if (STATE !== exp) begin
                nerrors++; $display("FAIL debounce_state k=%0d: got %0d want %0d", k, STATE, exp);
            end
        end
        release_keys();
        nchecks++;
        if (STATE !== 3'd1) begin
            nerrors++; $display("FAIL debounce_single_pulse: got %0d want 1", STATE);
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        press_keys(1'b1, 1'b0, 1'b0);
        nchecks++;
        if (STATE !== 3'd1) begin
            nerrors++; $display("FAIL run_enter: got %0d want 1", STATE);
        end
        release_keys();
        EN1HZ = 1'b1; #1;
        nchecks++;
        if (TICK !== 1'b1) begin
            nerrors++; $display("FAIL run_tick: got %b want 1", TICK);
        end
        @(negedge CLK); EN1HZ = 1'b0; #1;
        nchecks++;
        if (TICK !== 1'b0) begin
            nerrors++; $display("FAIL run_tick_low: got %b want 0", TICK);
        end
        // Tick arriving with the pause press still passes.
        @(negedge CLK);
        KEY_START = 1'b1;
        repeat (7) @(negedge CLK);
        EN1HZ = 1'b1; #1;
        nchecks++;
        if (TICK !== 1'b1) begin
            nerrors++; $display("FAIL pause_edge_tick: got %b want 1", TICK);
        end
        @(negedge CLK); EN1HZ = 1'b0;
        nchecks++;
        if (STATE !== 3'd2 || CLR !== 1'b0) begin
            nerrors++; $display("FAIL pause_enter: got state=%0d clr=%b want 2/0", STATE, CLR);
        end
        release_keys();
        EN1HZ = 1'b1; #1;
        nchecks++;
        if (TICK !== 1'b0) begin
            nerrors++; $display("FAIL pause_tick_blocked: got %b want 0", TICK);
        end
        @(negedge CLK); EN1HZ = 1'b0;
        press_keys(1'b0, 1'b1, 1'b0);
        nchecks++;
        if (STATE !== 3'd0 || CLR !== 1'b1) begin
            nerrors++; $display("FAIL pause_clear: got state=%0d clr=%b want 0/1", STATE, CLR);
        end
        @(negedge CLK);
        nchecks++;
        if (CLR !== 1'b0) begin
            nerrors++; $display("FAIL clear_one_cycle: got %b want 0", CLR);
        end
        release_keys();
    endtask

    task automatic test_set();
        do_reset();
        press_keys(1'b0, 1'b1, 1'b0);
        nchecks++;
        if (STATE !== 3'd3) begin
            nerrors++; $display("FAIL set_min_enter: got %0d want 3", STATE);
        end
        release_keys();
        for (int i = 0; i < 3; i++) begin
            press_keys(1'b0, 1'b0, 1'b1);
            nchecks++;
            if (INC_MIN !== 1'b1 || INC_SEC !== 1'b0 || STATE !== 3'd3) begin
                nerrors++;
                $display("FAIL inc_min_pulse %0d: got min=%b sec=%b state=%0d want 1/0/3",
                         i, INC_MIN, INC_SEC, STATE);
            end
            @(negedge CLK);
            nchecks++;
            if (INC_MIN !== 1'b0) begin
                nerrors++; $display("FAIL inc_min_width %0d: got %b want 0", i, INC_MIN);
            end
            release_keys();
        end
        press_keys(1'b0, 1'b1, 1'b0);
        nchecks++;
        if (STATE !== 3'd4) begin
            nerrors++; $display("FAIL set_sec_enter: got %0d want 4", STATE);
        end
        release_keys();
        for (int i = 0; i < 2; i++) begin
            press_keys(1'b0, 1'b0, 1'b1);
            nchecks++;
            if (INC_SEC !== 1'b1 || INC_MIN !== 1'b0 || STATE !== 3'd4) begin
                nerrors++;
                $display("FAIL inc_sec_pulse %0d: got sec=%b min=%b state=%0d want 1/0/4",
                         i, INC_SEC, INC_MIN, STATE);
            end
            @(negedge CLK);
            nchecks++;
            if (INC_SEC !== 1'b0) begin
                nerrors++; $display("FAIL inc_sec_width %0d: got %b want 0", i, INC_SEC);
            end
            release_keys();
        end
        press_keys(1'b0, 1'b1, 1'b0);
        nchecks++;
        if (STATE !== 3'd0 || CLR !== 1'b0) begin
            nerrors++; $display("FAIL set_exit: got state=%0d clr=%b want 0/0", STATE, CLR);
        end
        release_keys();
    endtask

    task automatic test_blink();
        logic exp_blank;
        logic exp_inc;
        do_reset();
        press_keys(1'b0, 1'b1, 1'b0);
        KEY_MODE = 1'b0;
        // Sample k=0 is the entry cycle. UP raw rises at k=20, so INC_MIN lands at k=28,
        // inside the blanked half-period that began at k=24.
        for (int k = 0; k <= 36; k++) begin
            if (k < 8)       exp_blank = 1'b0;
            else if (k < 16) exp_blank = 1'b1;
            else if (k < 24) exp_blank = 1'b0;
            else if (k < 28) exp_blank = 1'b1;
            else if (k < 36) exp_blank = 1'b0;
            else             exp_blank = 1'b1;
            exp_inc = (k == 28);
            nchecks++;
            if (BLANK_MIN !== exp_blank || BLANK_SEC !== 1'b0 || INC_MIN !== exp_inc) begin
                nerrors++;
                $display("FAIL blink k=%0d: got blank_min=%b blank_sec=%b inc=%b want %b/0/%b",
                         k, BLANK_MIN, BLANK_SEC, INC_MIN, exp_blank, exp_inc);
            end
            if (k == 20) KEY_UP = 1'b1;
            if (k == 30) KEY_UP = 1'b0;
            @(negedge CLK);
        end
        release_keys();
    endtask

    task automatic test_priority();
        do_reset();
        press_keys(1'b1, 1'b1, 1'b0);
        nchecks++;
        if (STATE !== 3'd1 || CLR !== 1'b0) begin
            nerrors++; $display("FAIL prio_start_mode: got state=%0d clr=%b want 1/0", STATE, CLR);
        end
        release_keys();
        do_reset();
        press_keys(1'b0, 1'b1, 1'b0);
        release_keys();
        press_keys(1'b0, 1'b1, 1'b1);
        nchecks++;
        if (STATE !== 3'd4 || INC_MIN !== 1'b0 || INC_SEC !== 1'b0) begin
            nerrors++;
            $display("FAIL prio_mode_up: got state=%0d inc_min=%b inc_sec=%b want 4/0/0",
                     STATE, INC_MIN, INC_SEC);
        end
        release_keys();
    endtask

    task automatic test_midrun_reset();
        do_reset();
        press_keys(1'b1, 1'b0, 1'b0);
        release_keys();
        EN1HZ = 1'b1; #1;
        nchecks++;
        if (TICK !== 1'b1) begin
            nerrors++; $display("FAIL rst_pre_tick: got %b want 1", TICK);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            nchecks++;
            if (STATE !== 3'd0 ||
                {TICK, CLR, INC_SEC, INC_MIN, BLANK_SEC, BLANK_MIN} !== 6'b0) begin
                nerrors++;
                $display("FAIL rst_midrun k=%0d: got state=%0d outs=%b want 0/000000", k, STATE,
                         {TICK, CLR, INC_SEC, INC_MIN, BLANK_SEC, BLANK_MIN});
            end
        end
        RST = 1'b0; EN1HZ = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_run_pause();
        test_set();
        test_blink();
        test_priority();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
